lutram_fifo16: RTL and testbench
================================

Name: lutram_fifo16

Overview:
- 16-entry first-word-fall-through FIFO built from DATA_W/2 instances of the team's 16x2 LUT-RAM primitive, plus a registered output stage.
- The block is the reader and flow-control wrapper around the distributed RAM:
  - it owns the write/read pointers and occupancy;
  - it turns the RAM's asynchronous read port into a registered valid/ready stream.
- Used as a small elastic buffer between pipeline stages in the Gowin-targeted designs.

Parameters:
- DATA_W, 8, payload width; must be even and ≥2. Instantiates DATA_W/2 RAM16SDP2 slices, bit pair k on slice k.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- WR_VALID  input  1  write request.
- WR_READY  output  1  FIFO can accept a write this cycle.
- WR_DATA  input  DATA_W  write payload.
- RD_VALID  output  1  RD_DATA holds a valid entry.
- RD_READY  input  1  consumer accepts RD_DATA this cycle.
- RD_DATA  output  DATA_W  head-of-queue data, registered.
- LEVEL  output  5  total entries held (RAM + output stage), 0..17.

Behaviour:
- Reset (async assert, release sync to CLK):
  - wr_ptr=0, rd_ptr=0, ram_cnt=0.
  - RD_VALID=0, RD_DATA=0, LEVEL=0, WR_READY=1.
  - RAM contents are not cleared; INIT parameters are all zero.
- Reset mid-operation discards all queued entries immediately. Outputs go to reset values without waiting for a clock edge.
- Storage:
  - wr_ptr and rd_ptr are 4 bits and wrap 15→0.
  - ram_cnt is 5 bits, range 0..16.
  - Total capacity is 17: 16 in RAM plus 1 in the output register.
- WR_READY = (ram_cnt != 16). It is decoded from registers only and has no combinational path from RD_READY.
- Write accept (WR_VALID & WR_READY):
  - RAM[wr_ptr] ← WR_DATA on the edge.
  - wr_ptr increments.
  - A write while WR_READY=0 is ignored; no state changes.
- Output load condition: (!RD_VALID | RD_READY) & (ram_cnt != 0). When it holds:
  - RD_DATA ← RAM[rd_ptr], using the asynchronous read port;
  - rd_ptr increments;
  - RD_VALID ← 1.
- Otherwise, if RD_VALID & RD_READY, then RD_VALID ← 0 and RD_DATA holds its last value.
- RD_READY while RD_VALID=0 has no effect.
- ram_cnt update: +1 on write accept only; −1 on output load only; unchanged when both occur in the same cycle.
- LEVEL = ram_cnt + RD_VALID, registered or derived from registers.
- Latency:
  - A write accepted at edge N becomes visible in RAM after N and is loaded to the output at edge N+1.
  - RD_VALID is high after N+1, i.e. 2 edges from write to visibility.
  - There is no write-to-output bypass.
- Throughput: one write and one read per cycle sustained once RD_VALID=1 and ram_cnt>0.
- Full: with ram_cnt=16 and a pop in the same cycle, WR_READY stays 0 that cycle. It rises the following cycle, since ram_cnt=15 after the load.
- Address collision: a read and a write to the same RAM address in one cycle is impossible by construction.
  - rd_ptr==wr_ptr occurs only when ram_cnt is 0 (no load) or 16 (no write).
  - No forwarding logic is required.
- Ordering: strict FIFO. Data is never duplicated or dropped across pointer wrap.

Test Plan:
- Reset then idle 5 cycles → RD_VALID=0, WR_READY=1, LEVEL=0, RD_DATA=0.
- Single write 8'hA5 at edge N, RD_READY=0 → RD_VALID=1 and RD_DATA=8'hA5 after edge N+1; LEVEL=1; holds until RD_READY pulse, then RD_VALID=0, LEVEL=0.
- Fill without reading, writing 8'h00..8'h10 → 17 accepted; WR_READY=0 after the 17th; LEVEL=17; an 18th write (8'hFF) is ignored; 17 pops return 8'h00..8'h10 in order.
- At full, assert RD_READY and WR_VALID together for one cycle → no write that cycle, WR_READY=1 the next cycle; LEVEL goes 17→16; a subsequent write is accepted (LEVEL=17).
- Continuous streaming of 40 incrementing words with RD_READY=1 and WR_VALID=1 every cycle → after 2-cycle startup, one word out per cycle; sequence 0..39 intact across 2 pointer wraps; LEVEL stable at 2.
- Assert RESET mid-stream with LEVEL=9 → RD_VALID=0 and LEVEL=0 immediately; after release, a new write 8'h3C is the first word read (no stale data).

Source files
------------

// File: rtl/lutram_fifo16_if.sv
// lutram_fifo16_if: write/read handshake bundle for lutram_fifo16.
//   slave  modport - the FIFO's view (accepts writes, presents head of queue)
//   master modport - the surrounding logic's view (producer + consumer)
// Signals:
//   WR_VALID/WR_READY/WR_DATA  write stream into the FIFO
//   RD_VALID/RD_READY/RD_DATA  read stream out of the FIFO (RD_DATA registered)
//   LEVEL                      entries held, RAM plus output register (0..17)
interface lutram_fifo16_if #(
  parameter int DATA_W = 8
);
  logic              WR_VALID;
  logic              WR_READY;
  logic [DATA_W-1:0] WR_DATA;
  logic              RD_VALID;
  logic              RD_READY;
  logic [DATA_W-1:0] RD_DATA;
  logic [4:0]        LEVEL;

  modport slave (
    input  WR_VALID, WR_DATA, RD_READY,
    output WR_READY, RD_VALID, RD_DATA, LEVEL
  );

  modport master (
    output WR_VALID, WR_DATA, RD_READY,
    input  WR_READY, RD_VALID, RD_DATA, LEVEL
  );
endinterface

// File: rtl/lutram_fifo16.sv
// lutram_fifo16: 16-entry first-word-fall-through FIFO on distributed RAM.
// DATA_W/2 slices of a 16x2 LUT-RAM hold the queue; a registered output
// stage turns the RAM's asynchronous read port into a valid/ready stream,
// so total capacity is 17 entries.
// Ports:
//   CLK    single clock, rising edge
//   RESET  asynchronous active-high reset (release synchronous to CLK)
//   f      lutram_fifo16_if.slave handshake bundle (see interface header)
// DATA_W must be even and >= 2; bit pair k lives in slice k.

// Behavioural model of the 16x2 simple-dual-port LUT-RAM primitive:
// synchronous write, asynchronous read, contents not reset.
module RAM16SDP2 (
  input  logic       CLK,
  input  logic       WRE,
  input  logic [3:0] WAD,
  input  logic [1:0] DI,
  input  logic [3:0] RAD,
  output logic [1:0] DO
);
  logic [1:0] mem [16];

  always_ff @(posedge CLK) begin
    if (WRE) begin
      mem[WAD] <= DI;
    end
  end

  assign DO = mem[RAD];
endmodule

module lutram_fifo16 #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  lutram_fifo16_if.slave    f
);
  logic [3:0]        wr_ptr_q,   wr_ptr_d;
  logic [3:0]        rd_ptr_q,   rd_ptr_d;
  logic [4:0]        ram_cnt_q,  ram_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_full;
  logic              ram_empty;
  logic              wr_acc;
  logic              out_load;

  // Full/empty come from ram_cnt only, so WR_READY has no path from RD_READY.
  assign ram_full  = (ram_cnt_q == 5'd16);
  assign ram_empty = (ram_cnt_q == 5'd0);
  assign wr_acc    = f.WR_VALID & ~ram_full;
  // Refill the output register when it is empty or being drained this cycle.
  assign out_load  = (~rd_valid_q | f.RD_READY) & ~ram_empty;

  // rd_ptr == wr_ptr only when the RAM is empty (no load) or full (no
  // write), so a same-address read/write never happens and no forwarding
  // is needed.
  for (genvar gi = 0; gi < DATA_W / 2; gi++) begin : g_slice
    RAM16SDP2 u_ram (
      .CLK (CLK),
      .WRE (wr_acc),
      .WAD (wr_ptr_q),
      .DI  (f.WR_DATA[2*gi +: 2]),
      .RAD (rd_ptr_q),
      .DO  (ram_rdata[2*gi +: 2])
    );
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 4'd1;
    end

    if (out_load) begin
      rd_ptr_d   = rd_ptr_q + 4'd1;
      rd_data_d  = ram_rdata;
      rd_valid_d = 1'b1;
    end else if (rd_valid_q & f.RD_READY) begin
      rd_valid_d = 1'b0;
    end

    case ({wr_acc, out_load})
      2'b10:   ram_cnt_d = ram_cnt_q + 5'd1;
      2'b01:   ram_cnt_d = ram_cnt_q - 5'd1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign f.WR_READY = ~ram_full;
  assign f.RD_VALID = rd_valid_q;
  assign f.RD_DATA  = rd_data_q;
  assign f.LEVEL    = ram_cnt_q + {4'd0, rd_valid_q};
endmodule

// File: tb/tb_lutram_fifo16.sv
// tb_lutram_fifo16: directed self-checking bench for lutram_fifo16.
// Inputs are driven 1 ns after the rising edge and outputs are sampled there.
module tb_lutram_fifo16;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lutram_fifo16_if #(.DATA_W(8)) bus ();

  lutram_fifo16 #(.DATA_W(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .f     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.WR_VALID = 1'b0;
    bus.WR_DATA  = '0;
    bus.RD_READY = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset and idle
    repeat (5) step();
    check("idle_rd_valid", bus.RD_VALID, 0);
    check("idle_wr_ready", bus.WR_READY, 1);
    check("idle_level",    bus.LEVEL,    0);
    check("idle_rd_data",  bus.RD_DATA,  0);
    $display("idle after reset: level=%0d", bus.LEVEL);

    // Single write, two-edge latency, held until popped
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 8'hA5;
    step();
    bus.WR_VALID = 1'b0;
    check("single_n_valid", bus.RD_VALID, 0);
    check("single_n_level", bus.LEVEL,    1);
    step();
    check("single_n1_valid", bus.RD_VALID, 1);
    check("single_n1_data",  bus.RD_DATA,  8'hA5);
    check("single_n1_level", bus.LEVEL,    1);
    repeat (3) step();
    check("single_hold_valid", bus.RD_VALID, 1);
    check("single_hold_data",  bus.RD_DATA,  8'hA5);
    bus.RD_READY = 1'b1;
    step();
    bus.RD_READY = 1'b0;
    check("single_pop_valid", bus.RD_VALID, 0);
    check("single_pop_level", bus.LEVEL,    0);
    $display("single write A5: popped, level=%0d", bus.LEVEL);

    // Fill with 00..10 without reading
    for (int i = 0; i < 17; i++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = i[7:0];
      check("fill_wr_ready", bus.WR_READY, 1);
      step();
      $display("fill write %02h: level=%0d", i[7:0], bus.LEVEL);
    end
    check("full_wr_ready", bus.WR_READY, 0);
    check("full_level",    bus.LEVEL,    17);
    bus.WR_DATA = 8'hFF;
    step();
    bus.WR_VALID = 1'b0;
    check("ovf_level",    bus.LEVEL,    17);
    check("ovf_wr_ready", bus.WR_READY, 0);
    check("ovf_rd_data",  bus.RD_DATA,  8'h00);

    // Pop and write together at full: write refused, space appears next cycle
    bus.RD_READY = 1'b1;
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 8'hEE;
    check("full_pop_wr_ready", bus.WR_READY, 0);
    step();
    bus.RD_READY = 1'b0;
    bus.WR_VALID = 1'b0;
    check("full_pop_next_wr_ready", bus.WR_READY, 1);
    check("full_pop_level",         bus.LEVEL,    16);
    check("full_pop_rd_data",       bus.RD_DATA,  8'h01);
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 8'h11;
    step();
    bus.WR_VALID = 1'b0;
    check("refill_level",    bus.LEVEL,    17);
    check("refill_wr_ready", bus.WR_READY, 0);
    $display("pop+write at full: EE refused, 11 accepted, level=%0d", bus.LEVEL);

    // Drain: expect 01..11 in order
    bus.RD_READY = 1'b1;
    for (int i = 1; i < 18; i++) begin
      check("drain_valid", bus.RD_VALID, 1);
      check("drain_data",  bus.RD_DATA,  i);
      $display("drain pop %02h (expected %02h)", bus.RD_DATA, i[7:0]);
      step();
    end
    bus.RD_READY = 1'b0;
    check("drain_empty_valid", bus.RD_VALID, 0);
    check("drain_empty_level", bus.LEVEL,    0);

    // Streaming 40 words through with both sides always ready
    bus.WR_VALID = 1'b1;
    bus.RD_READY = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      bus.WR_DATA = 8'(k - 1);
      step();
      if (k == 1) begin
        check("stream_start_valid", bus.RD_VALID, 0);
        check("stream_start_level", bus.LEVEL,    1);
      end else begin
        check("stream_valid", bus.RD_VALID, 1);
        check("stream_data",  bus.RD_DATA,  k - 2);
        check("stream_level", bus.LEVEL,    2);
      end
      $display("stream cycle %0d: valid=%0d data=%02h level=%0d", k, bus.RD_VALID, bus.RD_DATA, bus.LEVEL);
    end
    bus.WR_VALID = 1'b0;
    step();
    check("stream_tail_valid", bus.RD_VALID, 1);
    check("stream_tail_data",  bus.RD_DATA,  39);
    check("stream_tail_level", bus.LEVEL,    1);
    step();
    bus.RD_READY = 1'b0;
    check("stream_end_valid", bus.RD_VALID, 0);
    check("stream_end_level", bus.LEVEL,    0);

    // Reset with nine entries queued
    for (int i = 0; i < 9; i++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = 8'h50 + i[7:0];
      step();
    end
    bus.WR_VALID = 1'b0;
    check("pre_rst_level", bus.LEVEL,   9);
    check("pre_rst_data",  bus.RD_DATA, 8'h50);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid",    bus.RD_VALID, 0);
    check("async_rst_level",    bus.LEVEL,    0);
    check("async_rst_data",     bus.RD_DATA,  0);
    check("async_rst_wr_ready", bus.WR_READY, 1);
    $display("async reset mid-stream: level=%0d valid=%0d", bus.LEVEL, bus.RD_VALID);
    step();
    rst = 1'b0;
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 8'h3C;
    step();
    bus.WR_VALID = 1'b0;
    check("post_rst_n_valid", bus.RD_VALID, 0);
    step();
    check("post_rst_valid", bus.RD_VALID, 1);
    check("post_rst_data",  bus.RD_DATA,  8'h3C);
    check("post_rst_level", bus.LEVEL,    1);
    bus.RD_READY = 1'b1;
    step();
    bus.RD_READY = 1'b0;
    check("post_rst_pop_valid", bus.RD_VALID, 0);
    check("post_rst_pop_level", bus.LEVEL,    0);
    $display("post-reset write 3C: read %02h", 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
